// File: rtl/auth_req_dispatcher_pkg.sv
// Shared constants, state/select encodings and the ERROR header builder for the
// USB Type-C authentication request dispatcher.
package auth_req_dispatcher_pkg;

    localparam int MSG_LEN             = 64;
    localparam int HDR_W               = 32;
    localparam int PL_W                = MSG_LEN - HDR_W;
    localparam int SIZE_OF_HEADER_VARS = 8;

    localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
    localparam logic [7:0] GET_DIGESTS      = 8'h81;
    localparam logic [7:0] GET_CERTIFICATE  = 8'h82;
    localparam logic [7:0] CHALLENGE        = 8'h83;
    localparam logic [7:0] ERROR_RESP       = 8'h7F;

    localparam logic [7:0] ERR_INVALID_REQUEST = 8'h01;
    localparam logic [7:0] ERR_UNSUPPORTED     = 8'h02;
    localparam logic [7:0] ERR_UNSPECIFIED     = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE      = 2'd0,
        SEL_DIGESTS   = 2'd1,
        SEL_CERT      = 2'd2,
        SEL_CHALLENGE = 2'd3
    } sel_t;

    function automatic logic [HDR_W-1:0] error_header(input logic [7:0] code);
        return {PROTOCOL_VERSION, ERROR_RESP, code, 8'h00};
    endfunction

endpackage

// File: rtl/auth_req_dispatcher_timer.sv
// WAIT-state timeout counter: cleared on entry, counts enabled cycles and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed.
module auth_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count;

    // Expiry is taken from the registered count, so the FSM reacts one edge later.
    assign expired = (count >= 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= 8'h00;
        end else if (clear) begin
            count <= 8'h00;
        end else if (count_en && !expired) begin
            count <= count + 8'h01;
        end
    end

endmodule

// File: rtl/auth_req_dispatcher.sv
// Accepts one authentication request, enables one answer block, waits for its
// Ack/Error or a timeout, and holds the response until the transmit side takes it.
module auth_req_dispatcher
    import auth_req_dispatcher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           msg_valid,
    output logic                           msg_ready,
    input  logic [MSG_LEN-1:0]             auth_msg_in,
    output logic [MSG_LEN-1:0]             auth_msg_resp_out,
    output logic [SIZE_OF_HEADER_VARS-1:0] param1_out,
    output logic                           en_digests,
    output logic                           en_cert,
    output logic                           en_challenge,
    input  logic                           ack_digests,
    input  logic                           ack_cert,
    input  logic                           ack_challenge,
    input  logic                           err_digests,
    input  logic                           err_cert,
    input  logic                           err_challenge,
    input  logic [HDR_W-1:0]               hdr_digests,
    input  logic [HDR_W-1:0]               hdr_cert,
    input  logic [HDR_W-1:0]               hdr_challenge,
    input  logic [PL_W-1:0]                pl_digests,
    input  logic [PL_W-1:0]                pl_cert,
    input  logic [PL_W-1:0]                pl_challenge,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [HDR_W-1:0]               resp_header,
    output logic [PL_W-1:0]                resp_payload,
    output logic                           busy,
    output state_t                         fsm_state
);

    // Handshakes: a transfer happens on a posedge where valid && ready; the
    // source holds data stable while valid is high and ready is low.

    state_t                   state_q, state_d;
    sel_t                     sel_q, sel_d;
    logic [7:0]               err_code_q, err_code_d;
    logic [MSG_LEN-1:0]       msg_q, msg_d;
    logic [7:0]               param1_q, param1_d;
    logic [HDR_W-1:0]         hdr_q, hdr_d;
    logic [PL_W-1:0]          pl_q, pl_d;
    logic                     tmr_clear, tmr_count, tmr_expired;
    logic                     sel_ack, sel_err;
    logic [HDR_W-1:0]         sel_hdr;
    logic [PL_W-1:0]          sel_pl;

    auth_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset_L  (reset_L),
        .clear    (tmr_clear),
        .count_en (tmr_count),
        .expired  (tmr_expired)
    );

    assign msg_ready         = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign resp_valid        = (state_q == ST_RESP);
    assign fsm_state         = state_q;
    assign auth_msg_resp_out = msg_q;
    assign param1_out        = param1_q;
    assign resp_header       = hdr_q;
    assign resp_payload      = pl_q;
    assign en_digests        = (sel_q == SEL_DIGESTS);
    assign en_cert           = (sel_q == SEL_CERT);
    assign en_challenge      = (sel_q == SEL_CHALLENGE);

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_hdr = '0;
        sel_pl  = '0;
        case (sel_q)
            SEL_DIGESTS:   begin sel_ack = ack_digests;   sel_err = err_digests;   sel_hdr = hdr_digests;   sel_pl = pl_digests;   end
            SEL_CERT:      begin sel_ack = ack_cert;      sel_err = err_cert;      sel_hdr = hdr_cert;      sel_pl = pl_cert;      end
            SEL_CHALLENGE: begin sel_ack = ack_challenge; sel_err = err_challenge; sel_hdr = hdr_challenge; sel_pl = pl_challenge; end
            default:       ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        err_code_d = err_code_q;
        msg_d      = msg_q;
        param1_d   = param1_q;
        hdr_d      = hdr_q;
        pl_d       = pl_q;
        tmr_clear  = 1'b0;
        tmr_count  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (msg_valid) begin
                    msg_d    = auth_msg_in;
                    param1_d = auth_msg_in[MSG_LEN-17 -: 8];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Rejected requests still pass through WAIT (no enable) so the
                // error response appears two edges after acceptance.
                tmr_clear  = 1'b1;
                err_code_d = 8'h00;
                state_d    = ST_WAIT;
                if (msg_q[MSG_LEN-1 -: 8] != PROTOCOL_VERSION) begin
                    err_code_d = ERR_UNSUPPORTED;
                end else begin
                    case (msg_q[MSG_LEN-9 -: 8])
                        GET_DIGESTS:     sel_d = SEL_DIGESTS;
                        GET_CERTIFICATE: sel_d = SEL_CERT;
                        CHALLENGE:       sel_d = SEL_CHALLENGE;
                        default:         err_code_d = ERR_INVALID_REQUEST;
                    endcase
                end
            end
            ST_WAIT: begin
                if (err_code_q != 8'h00) begin
                    hdr_d   = error_header(err_code_q);
                    pl_d    = '0;
                    state_d = ST_RESP;
                end else if (sel_err) begin
                    hdr_d   = error_header(ERR_INVALID_REQUEST);
                    pl_d    = '0;
                    sel_d   = SEL_NONE;
                    state_d = ST_RESP;
                end else if (sel_ack) begin
                    hdr_d   = sel_hdr;
                    pl_d    = sel_pl;
                    sel_d   = SEL_NONE;
                    state_d = ST_RESP;
                end else if (tmr_expired) begin
                    hdr_d   = error_header(ERR_UNSPECIFIED);
                    pl_d    = '0;
                    sel_d   = SEL_NONE;
                    state_d = ST_RESP;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_NONE;
            err_code_q <= 8'h00;
            msg_q      <= '0;
            param1_q   <= 8'h00;
            hdr_q      <= '0;
            pl_q       <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            err_code_q <= err_code_d;
            msg_q      <= msg_d;
            param1_q   <= param1_d;
            hdr_q      <= hdr_d;
            pl_q       <= pl_d;
        end
    end

endmodule

// File: tb/tb_auth_req_dispatcher.sv
// Directed bench for auth_req_dispatcher with TIMEOUT_CYCLES = 4.
module tb_auth_req_dispatcher;
    import auth_req_dispatcher_pkg::*;

    logic              clk = 1'b0;
    logic              reset_L;
    logic              msg_valid, msg_ready;
    logic [63:0]       auth_msg_in, auth_msg_resp_out;
    logic [7:0]        param1_out;
    logic              en_digests, en_cert, en_challenge;
    logic              ack_digests, ack_cert, ack_challenge;
    logic              err_digests, err_cert, err_challenge;
    logic [31:0]       hdr_digests, hdr_cert, hdr_challenge;
    logic [31:0]       pl_digests, pl_cert, pl_challenge;
    logic              resp_valid, resp_ready;
    logic [31:0]       resp_header, resp_payload;
    logic              busy;
    state_t            fsm_state;

    int compared   = 0;
    int mismatched = 0;

    auth_req_dispatcher #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .auth_msg_in(auth_msg_in),
        .auth_msg_resp_out(auth_msg_resp_out), .param1_out(param1_out),
        .en_digests(en_digests), .en_cert(en_cert), .en_challenge(en_challenge),
        .ack_digests(ack_digests), .ack_cert(ack_cert), .ack_challenge(ack_challenge),
        .err_digests(err_digests), .err_cert(err_cert), .err_challenge(err_challenge),
        .hdr_digests(hdr_digests), .hdr_cert(hdr_cert), .hdr_challenge(hdr_challenge),
        .pl_digests(pl_digests), .pl_cert(pl_cert), .pl_challenge(pl_challenge),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_header(resp_header), .resp_payload(resp_payload),
        .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] m);
        auth_msg_in = m;
        msg_valid   = 1'b1;
        tick();
        msg_valid   = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0; msg_valid = 1'b0; auth_msg_in = '0; resp_ready = 1'b0;
        {ack_digests, ack_cert, ack_challenge} = 3'b000;
        {err_digests, err_cert, err_challenge} = 3'b000;
        hdr_digests = 32'hD1D1_D1D1; hdr_cert = 32'hC2C2_C2C2; hdr_challenge = 32'h0183_AA55;
        pl_digests  = 32'hDDDD_0001; pl_cert  = 32'hCCCC_0002; pl_challenge  = 32'h1234_5678;
        tick(); tick();

        check("rst_msg_ready", msg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_enables", {en_digests, en_cert, en_challenge}, 0);
        check("rst_resp_header", resp_header, 0);
        check("rst_resp_payload", resp_payload, 0);
        check("rst_msg_out", auth_msg_resp_out, 0);
        check("rst_param1", param1_out, 0);
        check("rst_state", fsm_state, ST_IDLE);
        reset_L = 1'b1;
        tick();

        // CHALLENGE, acked one cycle after enable; non-selected err ignored
        send({8'h01, 8'h83, 8'h02, 8'h00, 32'hCAFE_0001});
        check("ch_busy", busy, 1);
        check("ch_msg_ready", msg_ready, 0);
        check("ch_param1", param1_out, 8'h02);
        check("ch_msg_out", auth_msg_resp_out, {8'h01, 8'h83, 8'h02, 8'h00, 32'hCAFE_0001});
        tick();
        check("ch_enables", {en_digests, en_cert, en_challenge}, 3'b001);
        check("ch_valid_n1", resp_valid, 0);
        err_digests = 1'b1;
        tick();
        check("ch_valid_n2", resp_valid, 0);
        check("ch_en_hold", en_challenge, 1);
        ack_challenge = 1'b1;
        tick();
        ack_challenge = 1'b0; err_digests = 1'b0;
        check("ch_valid_n3", resp_valid, 1);
        check("ch_header", resp_header, 32'h0183_AA55);
        check("ch_payload", resp_payload, 32'h1234_5678);
        check("ch_en_drop", {en_digests, en_cert, en_challenge}, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("ch_valid_clr", resp_valid, 0);
        check("ch_ready_back", msg_ready, 1);
        check("ch_header_keep", resp_header, 32'h0183_AA55);

        // Unsupported version, then a 10-cycle stall with a pending new request
        send({8'h02, 8'h81, 8'h00, 8'h00, 32'hFFFF_FFFF});
        check("ver_en_n1", {en_digests, en_cert, en_challenge}, 0);
        tick();
        check("ver_valid_n1", resp_valid, 0);
        tick();
        check("ver_valid_n2", resp_valid, 1);
        check("ver_header", resp_header, 32'h017F_0200);
        check("ver_payload", resp_payload, 0);
        auth_msg_in = {8'h01, 8'h82, 8'h07, 8'h00, 32'h0};
        msg_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", resp_valid, 1);
            check("stall_header", resp_header, 32'h017F_0200);
            check("stall_msg_ready", msg_ready, 0);
        end
        msg_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("stall_ignored", auth_msg_resp_out, {8'h02, 8'h81, 8'h00, 8'h00, 32'hFFFF_FFFF});
        check("stall_idle", msg_ready, 1);

        // Unknown type 0x84, accepted on the cycle resp_valid rises
        send({8'h01, 8'h84, 8'h00, 8'h00, 32'h5555_AAAA});
        tick();
        check("typ_en", {en_digests, en_cert, en_challenge}, 0);
        tick();
        check("typ_valid", resp_valid, 1);
        check("typ_header", resp_header, 32'h017F_0100);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("typ_one_cycle", msg_ready, 1);

        // GET_CERTIFICATE with ack and err together: err wins
        send({8'h01, 8'h82, 8'h01, 8'h00, 32'h0});
        tick();
        check("crt_enables", {en_digests, en_cert, en_challenge}, 3'b010);
        tick();
        ack_cert = 1'b1; err_cert = 1'b1;
        tick();
        ack_cert = 1'b0; err_cert = 1'b0;
        check("crt_valid", resp_valid, 1);
        check("crt_header", resp_header, 32'h017F_0100);
        check("crt_payload", resp_payload, 0);
        check("crt_en_drop", en_cert, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // GET_DIGESTS with no answer: timeout after 4 WAIT cycles
        send({8'h01, 8'h81, 8'h00, 8'h00, 32'h0});
        tick();
        check("to_enables", {en_digests, en_cert, en_challenge}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_wait_valid", resp_valid, 0);
            check("to_wait_en", en_digests, 1);
        end
        tick();
        check("to_valid", resp_valid, 1);
        check("to_header", resp_header, 32'h017F_0400);
        check("to_en_drop", en_digests, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // GET_DIGESTS acked, then asynchronous reset while waiting on a second one
        send({8'h01, 8'h81, 8'h03, 8'h00, 32'h0});
        tick();
        tick();
        ack_digests = 1'b1;
        tick();
        ack_digests = 1'b0;
        check("dg_header", resp_header, 32'hD1D1_D1D1);
        check("dg_payload", resp_payload, 32'hDDDD_0001);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        send({8'h01, 8'h81, 8'h05, 8'h00, 32'h0});
        tick();
        check("rw_en", en_digests, 1);
        reset_L = 1'b0;
        #1;
        check("rw_en_clr", {en_digests, en_cert, en_challenge}, 0);
        check("rw_busy", busy, 0);
        check("rw_msg_ready", msg_ready, 1);
        check("rw_param1", param1_out, 0);
        check("rw_msg_out", auth_msg_resp_out, 0);
        check("rw_header", resp_header, 0);
        check("rw_payload", resp_payload, 0);
        check("rw_valid", resp_valid, 0);
        tick();
        reset_L = 1'b1;
        tick();
        check("rw_state", fsm_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
